// File: rtl/ctrl_adder_pipe_pkg.sv
// rtl/ctrl_adder_pipe_pkg.sv - shared constants and operand typedef for the controlled adder pipe
package ctrl_adder_pipe_pkg;

    localparam int W_DEF     = 16;
    localparam int HALF_DEF  = W_DEF / 2;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [W_DEF-1:0] a;
        logic [W_DEF-1:0] b;
        logic [W_DEF-1:0] ctrl;
    } operand_t;

endpackage

// File: rtl/ctrl_add_half.sv
// rtl/ctrl_add_half.sv - combinational controlled adder slice, exact or OR-approximate per bit
module ctrl_add_half
    import ctrl_adder_pipe_pkg::*;
#(
    parameter int N = HALF_DEF
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] ec_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic c;

    // An approximate bit drops the incoming carry and emits none, splitting the chain.
    always_comb begin
        c     = cin_i;
        sum_o = '0;
        for (int i = 0; i < N; i++) begin
            if (ec_i[i]) begin
                sum_o[i] = a_i[i] ^ b_i[i] ^ c;
                c        = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
            end else begin
                sum_o[i] = a_i[i] | b_i[i];
                c        = 1'b0;
            end
        end
        cout_o = c;
    end

endmodule

// File: rtl/ctrl_adder_pipe.sv
// rtl/ctrl_adder_pipe.sv - two-stage valid/ready controlled approximate adder with op counter
module ctrl_adder_pipe
    import ctrl_adder_pipe_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_ctrl,
    input  logic             exact_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] op_count
);

    localparam int H = W / 2;

    logic [W-1:0]     ec_d;
    logic [H-1:0]     sum_lo_d;
    logic             c_mid_d;
    logic [H-1:0]     sum_hi_d;
    logic             cout_d;

    logic             s1_v_q;
    logic [H-1:0]     s1_sum_lo_q;
    logic             s1_c_q;
    logic [H-1:0]     s1_a_hi_q;
    logic [H-1:0]     s1_b_hi_q;
    logic [H-1:0]     s1_ec_hi_q;

    logic             out_valid_q;
    logic [W-1:0]     out_sum_q;
    logic             out_cout_q;
    logic [CNT_W-1:0] op_count_q;

    logic             accept;
    logic             stage2_adv;

    assign ec_d = in_ctrl | {W{exact_mode}};

    ctrl_add_half #(.N(H)) u_lo (
        .a_i   (in_a[H-1:0]),
        .b_i   (in_b[H-1:0]),
        .ec_i  (ec_d[H-1:0]),
        .cin_i (1'b0),
        .sum_o (sum_lo_d),
        .cout_o(c_mid_d)
    );

    ctrl_add_half #(.N(H)) u_hi (
        .a_i   (s1_a_hi_q),
        .b_i   (s1_b_hi_q),
        .ec_i  (s1_ec_hi_q),
        .cin_i (s1_c_q),
        .sum_o (sum_hi_d),
        .cout_o(cout_d)
    );

    // Ready is combinational through stage 2 so a full pipe still streams one op per cycle.
    assign stage2_adv = s1_v_q & (~out_valid_q | out_ready);
    assign in_ready   = ~s1_v_q | stage2_adv;
    assign accept     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_sum_lo_q <= '0;
            s1_c_q      <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            s1_ec_hi_q  <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            if (accept) begin
                s1_v_q      <= 1'b1;
                s1_sum_lo_q <= sum_lo_d;
                s1_c_q      <= c_mid_d;
                s1_a_hi_q   <= in_a[W-1:H];
                s1_b_hi_q   <= in_b[W-1:H];
                s1_ec_hi_q  <= ec_d[W-1:H];
            end else if (stage2_adv) begin
                s1_v_q <= 1'b0;
            end

            if (stage2_adv) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= {sum_hi_d, s1_sum_lo_q};
                out_cout_q  <= cout_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && out_ready) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign op_count  = op_count_q;

endmodule
